timer_cmp: RTL and testbench
============================

TIMER_CMP -- requirements
Module: timer_cmp

Interface
REQ-001 The block SHALL have parameter DW, default 32, giving the width of the time value and of every register.
REQ-002 Port CLK SHALL be an input of width 1 and the single clock; all state updates occur on its rising edge.
REQ-003 Port RESET_N SHALL be an input of width 1 and the asynchronous, active-low reset.
REQ-004 Port TIME SHALL be an input of width DW carrying the millisecond count driven by the Timer Do output.
REQ-005 Port WE SHALL be an input of width 1 acting as the bus write strobe.
REQ-006 Port ADDR SHALL be an input of width 2 selecting the register: 0 CMP, 1 PERIOD, 2 CTRL, 3 STATUS.
REQ-007 Port Di SHALL be an input of width DW carrying the write data.
REQ-008 Port Do SHALL be an output of width DW carrying the read data of the register selected by ADDR.
REQ-009 Port IRQ SHALL be an output of width 1 that is the level interrupt to the CPU.
REQ-010 Port IACK SHALL be an input of width 1 that is a one-cycle interrupt acknowledge.

Function
REQ-011 Do SHALL be combinational from ADDR (zero read latency); STATUS layout is bit0 PEND, bit1 OVR, bits[31:16] FIRECNT, and all other bits read 0.
REQ-012 CTRL SHALL be bit0 EN and bit1 PERIODIC; all other bits are write-ignored and read 0.
REQ-013 A write with WE=1 SHALL update the addressed register on the next edge; a STATUS write is write-1-to-clear on bits 0 and 1 and leaves FIRECNT unchanged.
REQ-014 The state machine SHALL have three states: IDLE, ARMED and FIRED.
REQ-015 Any state SHALL go to IDLE when a CTRL write has EN=0.
REQ-016 IDLE SHALL go to ARMED when a CTRL write has EN=1.
REQ-017 In ARMED, a match (TIME == CMP) SHALL move the block to FIRED for exactly one cycle.
REQ-018 FIRED SHALL set PEND, saturating-increment FIRECNT (holding at 16'hFFFF) and set IRQ one cycle after the match.
REQ-019 In FIRED with PERIODIC=1 and PERIOD!=0, CMP SHALL become CMP+PERIOD modulo 2^DW and the state SHALL return to ARMED.
REQ-020 In FIRED otherwise (one-shot), EN SHALL clear and the state SHALL go to IDLE; PERIOD=0 with PERIODIC=1 SHALL behave as one-shot.
REQ-021 IRQ SHALL equal PEND; IACK=1 SHALL clear PEND on the next edge.
REQ-022 When a match occurs while PEND=1, OVR SHALL be set and PEND SHALL remain 1.
REQ-023 When IACK and a FIRED event occur in the same cycle, the FIRED event SHALL win: PEND stays 1 and OVR is not set.
REQ-024 When a CMP or CTRL write coincides with a match in the same cycle, the write SHALL win and no fire occurs that cycle.
REQ-025 Each TIME value SHALL produce at most one fire; a CMP advance that wraps past 2^DW-1 SHALL match normally after TIME wraps.

Reset
REQ-026 Asserting RESET_N=0 SHALL immediately clear CMP, PERIOD, CTRL, PEND, OVR and FIRECNT, force IDLE and drive IRQ=0, including mid-operation.
REQ-027 After RESET_N deasserts, the block SHALL remain in IDLE until a CTRL write with EN=1.

Structure
REQ-028 The register address constants, CTRL/STATUS bit positions and state encodings SHALL live in the shared package timer_pkg, also used by the CPU bus decoder.
REQ-029 The block SHALL be a single module with no sub-module; TIME SHALL be consumed unsynchronised because it shares CLK.

Verification
REQ-030 Scenario: CMP=5, CTRL=1, TIME ramps 0->6 -> IRQ rises one cycle after TIME=5, state returns to IDLE, CTRL reads 0, FIRECNT=1.
REQ-031 Scenario: CMP=3, PERIOD=4, CTRL=3 -> fires occur at TIME 3, 7 and 11, and CMP reads 15 after the third fire.
REQ-032 Scenario: periodic fire with no IACK, then a second match -> STATUS reads 0x00020003; a subsequent W1C of 0x3 reads 0x00020000.
REQ-033 Scenario: IACK coincident with FIRED -> PEND=1 and OVR=0.
REQ-034 Scenario: CMP=32'hFFFFFFFE, PERIOD=4, periodic -> after the fire CMP=2 and the next fire occurs at TIME=2 after wrap.
REQ-035 Scenario: RESET_N pulsed low while ARMED with IRQ=1 -> IRQ=0 immediately and all registers read 0.

Source files
------------

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
//   Shared definitions for the compare timer and the CPU bus decoder:
//   register addresses, CTRL/STATUS bit positions, state encodings and a
//   helper that packs the STATUS read word.
// ---------------------------------------------------------------------------
package timer_pkg;

    // Register map (2-bit word address)
    localparam logic [1:0] ADDR_CMP    = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // CTRL bits
    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_PERIODIC_BIT = 1;

    // STATUS bits
    localparam int STATUS_PEND_BIT    = 0;
    localparam int STATUS_OVR_BIT     = 1;
    localparam int STATUS_FIRECNT_LSB = 16;

    localparam int          FIRECNT_W   = 16;
    localparam logic [15:0] FIRECNT_MAX = 16'hFFFF;

    // State encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FIRED = 2'd2;

    // Pack the 32-bit STATUS read word; unused bits read 0.
    function automatic logic [31:0] status_word(input logic        pend,
                                                input logic        ovr,
                                                input logic [15:0] firecnt);
        logic [31:0] w;
        w                                                = '0;
        w[STATUS_PEND_BIT]                               = pend;
        w[STATUS_OVR_BIT]                                = ovr;
        w[STATUS_FIRECNT_LSB +: FIRECNT_W]               = firecnt;
        return w;
    endfunction

endpackage

// File: rtl/timer_cmp.sv
// ---------------------------------------------------------------------------
// timer_cmp
//   Compare/interrupt block that watches the millisecond TIME count and
//   raises a level interrupt when it equals CMP. Supports one-shot and
//   periodic (auto-reload CMP += PERIOD) operation, overrun detection and
//   a saturating fire counter.
//
// Ports
//   CLK      single clock, rising edge
//   RESET_N  asynchronous active-low reset
//   TIME     millisecond count from the timer (same clock domain)
//   WE       bus write strobe
//   ADDR     register select: 0 CMP, 1 PERIOD, 2 CTRL, 3 STATUS
//   Di       write data
//   Do       combinational read data of the register selected by ADDR
//   IRQ      level interrupt (equals STATUS.PEND)
//   IACK     one-cycle interrupt acknowledge, clears PEND
// ---------------------------------------------------------------------------
module timer_cmp
    import timer_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic [DW-1:0] TIME,
    input  logic          WE,
    input  logic [1:0]    ADDR,
    input  logic [DW-1:0] Di,
    output logic [DW-1:0] Do,
    output logic          IRQ,
    input  logic          IACK
);

    logic [DW-1:0]        cmp_q,       cmp_d;
    logic [DW-1:0]        period_q,    period_d;
    logic                 en_q,        en_d;
    logic                 periodic_q,  periodic_d;
    logic                 pend_q,      pend_d;
    logic                 ovr_q,       ovr_d;
    logic [FIRECNT_W-1:0] firecnt_q,   firecnt_d;
    logic [1:0]           state_q,     state_d;
    // Remembers the TIME value of the last fire so a TIME that stays put
    // cannot fire twice (e.g. a one-shot re-armed while TIME is frozen).
    logic                 hold_q,      hold_d;
    logic [DW-1:0]        hold_time_q, hold_time_d;

    logic wr_cmp, wr_period, wr_ctrl, wr_status;
    logic clr_pend, clr_ovr;
    logic match, fire, reload;

    assign wr_cmp    = WE && (ADDR == ADDR_CMP);
    assign wr_period = WE && (ADDR == ADDR_PERIOD);
    assign wr_ctrl   = WE && (ADDR == ADDR_CTRL);
    assign wr_status = WE && (ADDR == ADDR_STATUS);

    assign clr_pend = wr_status && Di[STATUS_PEND_BIT];
    assign clr_ovr  = wr_status && Di[STATUS_OVR_BIT];

    assign match = (TIME == cmp_q) && !(hold_q && (TIME == hold_time_q));
    // A CMP or CTRL write in the match cycle takes priority over the fire.
    assign fire  = (state_q == ST_ARMED) && match && !wr_cmp && !wr_ctrl;
    // PERIOD == 0 degrades periodic mode to one-shot.
    assign reload = (state_q == ST_FIRED) && periodic_q && (period_q != '0);

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cmp_d       = cmp_q;
        period_d    = period_q;
        en_d        = en_q;
        periodic_d  = periodic_q;
        pend_d      = pend_q;
        ovr_d       = ovr_q;
        firecnt_d   = firecnt_q;
        state_d     = state_q;
        hold_d      = hold_q;
        hold_time_d = hold_time_q;

        // Sequencer
        case (state_q)
            ST_ARMED: if (fire) state_d = ST_FIRED;
            ST_FIRED: state_d = reload ? ST_ARMED : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (wr_ctrl) state_d = Di[CTRL_EN_BIT] ? ST_ARMED : ST_IDLE;

        // CMP: bus write beats the periodic advance
        if (wr_cmp)      cmp_d = Di;
        else if (reload) cmp_d = cmp_q + period_q;

        if (wr_period) period_d = Di;

        // CTRL: one-shot completion drops EN unless software rewrites CTRL
        if (wr_ctrl) begin
            en_d       = Di[CTRL_EN_BIT];
            periodic_d = Di[CTRL_PERIODIC_BIT];
        end else if ((state_q == ST_FIRED) && !reload) begin
            en_d = 1'b0;
        end

        // PEND: a fire beats both IACK and the W1C clear
        if (IACK || clr_pend) pend_d = 1'b0;
        if (fire)             pend_d = 1'b1;

        // OVR: a fire on top of an unacknowledged PEND is an overrun
        if (clr_ovr) ovr_d = 1'b0;
        if (fire && pend_q && !IACK && !clr_pend) ovr_d = 1'b1;

        if (fire && (firecnt_q != FIRECNT_MAX)) firecnt_d = firecnt_q + 1'b1;

        if (fire) begin
            hold_d      = 1'b1;
            hold_time_d = TIME;
        end else if (TIME != hold_time_q) begin
            hold_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cmp_q       <= '0;
            period_q    <= '0;
            en_q        <= 1'b0;
            periodic_q  <= 1'b0;
            pend_q      <= 1'b0;
            ovr_q       <= 1'b0;
            firecnt_q   <= '0;
            state_q     <= ST_IDLE;
            hold_q      <= 1'b0;
            hold_time_q <= '0;
        end else begin
            cmp_q       <= cmp_d;
            period_q    <= period_d;
            en_q        <= en_d;
            periodic_q  <= periodic_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            firecnt_q   <= firecnt_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_time_q <= hold_time_d;
        end
    end

    // Zero-latency read mux
    always_comb begin
        Do = '0;
        case (ADDR)
            ADDR_CMP:    Do = cmp_q;
            ADDR_PERIOD: Do = period_q;
            ADDR_CTRL:   Do = DW'({periodic_q, en_q});
            default:     Do = DW'(status_word(pend_q, ovr_q, firecnt_q));
        endcase
    end

    assign IRQ = pend_q;

endmodule

// File: tb/tb_timer_cmp.sv
// ---------------------------------------------------------------------------
// tb_timer_cmp
//   Self-checking bench for timer_cmp: register read/write table, directed
//   multi-cycle scenarios, and a randomized run against a reference model.
// ---------------------------------------------------------------------------
module tb_timer_cmp;
    import timer_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] TIME;
    logic        WE;
    logic [1:0]  ADDR;
    logic [31:0] Di;
    logic [31:0] Do;
    logic        IRQ;
    logic        IACK;

    int n_checks = 0;
    int n_errors = 0;

    timer_cmp #(.DW(32)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .TIME    (TIME),
        .WE      (WE),
        .ADDR    (ADDR),
        .Di      (Di),
        .Do      (Do),
        .IRQ     (IRQ),
        .IACK    (IACK)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        WE = 1'b0; IACK = 1'b0; ADDR = 2'd0; Di = '0; TIME = '0;
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        WE = 1'b1; ADDR = a; Di = d;
        step();
        WE = 1'b0; Di = '0;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        ADDR = a;
        #1;
        check(name, Do, exp);
    endtask

    // Drive TIME = start, start+1, ... for n cycles and record every TIME
    // value at which FIRECNT advanced on the following edge.
    logic [31:0] fires_q[$];

    task automatic ramp(input logic [31:0] start, input int n);
        logic [15:0] prev_cnt;
        logic [31:0] prev_t;
        fires_q.delete();
        ADDR = ADDR_STATUS;
        TIME = start;
        #1;
        prev_cnt = Do[31:16];
        prev_t   = start;
        for (int i = 0; i < n; i++) begin
            TIME = start + 32'(i);
            #1;
            if (Do[31:16] != prev_cnt) fires_q.push_back(prev_t);
            prev_cnt = Do[31:16];
            prev_t   = TIME;
            step();
        end
    endtask

    function automatic logic [31:0] fire_at(input int i);
        if (i < fires_q.size()) return fires_q[i];
        return 32'hDEAD_0000;
    endfunction

    // ----------------------------------------------------------------------
    // Reference model: block is armed whenever enabled and not in the single
    // post-fire bookkeeping cycle; a fire schedules that bookkeeping.
    // ----------------------------------------------------------------------
    logic [31:0] m_cmp, m_period, m_hold_t;
    logic        m_en, m_periodic, m_pend, m_ovr, m_post, m_hold;
    logic [15:0] m_cnt;

    task automatic model_reset();
        m_cmp = '0; m_period = '0; m_hold_t = '0;
        m_en = 0; m_periodic = 0; m_pend = 0; m_ovr = 0; m_post = 0; m_hold = 0;
        m_cnt = '0;
    endtask

    function automatic logic [31:0] model_do(input logic [1:0] a);
        case (a)
            2'd0:    return m_cmp;
            2'd1:    return m_period;
            2'd2:    return {30'd0, m_periodic, m_en};
            default: return {m_cnt, 14'd0, m_ovr, m_pend};
        endcase
    endfunction

    task automatic model_step(input logic we, input logic [1:0] a, input logic [31:0] d,
                              input logic ack, input logic [31:0] t);
        logic wcmp, wper, wctrl, wst, fire, reload, ackd;
        logic [31:0] n_cmp;
        logic n_en, n_pend, n_ovr;
        wcmp  = we && a == 2'd0;
        wper  = we && a == 2'd1;
        wctrl = we && a == 2'd2;
        wst   = we && a == 2'd3;
        fire  = m_en && !m_post && t == m_cmp && !wcmp && !wctrl && !(m_hold && t == m_hold_t);
        reload = m_post && m_periodic && m_period != 0;
        ackd  = ack || (wst && d[0]);

        n_cmp  = wcmp ? d : (reload ? m_cmp + m_period : m_cmp);
        n_en   = wctrl ? d[0] : ((m_post && !reload) ? 1'b0 : m_en);
        n_pend = fire ? 1'b1 : (ackd ? 1'b0 : m_pend);
        n_ovr  = (fire && m_pend && !ackd) ? 1'b1 : ((wst && d[1]) ? 1'b0 : m_ovr);

        if (fire && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        if (wper)  m_period = d;
        if (wctrl) m_periodic = d[1];
        if (fire) begin
            m_hold = 1; m_hold_t = t;
        end else if (t != m_hold_t) begin
            m_hold = 0;
        end
        m_cmp  = n_cmp;
        m_en   = n_en;
        m_pend = n_pend;
        m_ovr  = n_ovr;
        m_post = fire;
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } vec_t;

    vec_t vecs[8];
    int   first_irq;
    logic [31:0] t_rnd;

    initial begin
        vecs[0] = '{ADDR_CMP,    32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{ADDR_PERIOD, 32'h1234_5678, 32'h1234_5678};
        vecs[2] = '{ADDR_CTRL,   32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{ADDR_CTRL,   32'h0000_0003, 32'h0000_0003};
        vecs[4] = '{ADDR_STATUS, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5] = '{ADDR_CTRL,   32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{ADDR_PERIOD, 32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{ADDR_CMP,    32'h0000_0000, 32'h0000_0000};

        do_reset();

        // Reset state
        check("rst_irq", 32'(IRQ), 32'd0);
        rd_check("rst_cmp",    ADDR_CMP,    32'd0);
        rd_check("rst_period", ADDR_PERIOD, 32'd0);
        rd_check("rst_ctrl",   ADDR_CTRL,   32'd0);
        rd_check("rst_status", ADDR_STATUS, 32'd0);

        // Register access table (TIME held at 0, never matching while armed)
        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rexp);
        end
        rd_check("vec_nofire", ADDR_STATUS, 32'd0);

        // One-shot: IRQ one cycle after TIME=5, then back to idle
        do_reset();
        wr(ADDR_CMP, 32'd5);
        wr(ADDR_CTRL, 32'd1);
        first_irq = -1;
        for (int t = 0; t <= 6; t++) begin
            TIME = 32'(t);
            #1;
            if (IRQ && first_irq < 0) first_irq = t;
            step();
        end
        check("oneshot_irq_rise", 32'(first_irq), 32'd6);
        rd_check("oneshot_ctrl", ADDR_CTRL, 32'd0);
        rd_check("oneshot_status", ADDR_STATUS, 32'h0001_0001);
        ramp(32'd0, 8);
        check("oneshot_idle_nfires", 32'(fires_q.size()), 32'd0);
        IACK = 1'b1;
        step();
        IACK = 1'b0;
        #1;
        check("iack_clears_irq", 32'(IRQ), 32'd0);

        // Periodic: fires at 3, 7, 11
        do_reset();
        wr(ADDR_CMP, 32'd3);
        wr(ADDR_PERIOD, 32'd4);
        wr(ADDR_CTRL, 32'd3);
        ramp(32'd0, 13);
        check("per_nfires", 32'(fires_q.size()), 32'd3);
        check("per_fire0", fire_at(0), 32'd3);
        check("per_fire1", fire_at(1), 32'd7);
        check("per_fire2", fire_at(2), 32'd11);
        rd_check("per_cmp", ADDR_CMP, 32'd15);
        rd_check("per_status", ADDR_STATUS, 32'h0003_0003);

        // Overrun then W1C
        do_reset();
        wr(ADDR_CMP, 32'd3);
        wr(ADDR_PERIOD, 32'd4);
        wr(ADDR_CTRL, 32'd3);
        ramp(32'd0, 9);
        rd_check("ovr_status", ADDR_STATUS, 32'h0002_0003);
        wr(ADDR_STATUS, 32'd3);
        rd_check("w1c_status", ADDR_STATUS, 32'h0002_0000);
        check("w1c_irq", 32'(IRQ), 32'd0);

        // IACK coincident with a fire while PEND is already set
        do_reset();
        wr(ADDR_CMP, 32'd3);
        wr(ADDR_PERIOD, 32'd4);
        wr(ADDR_CTRL, 32'd3);
        ramp(32'd0, 7);
        TIME = 32'd7;
        IACK = 1'b1;
        step();
        IACK = 1'b0;
        rd_check("iack_fire_status", ADDR_STATUS, 32'h0002_0001);
        IACK = 1'b1;
        step();
        IACK = 1'b0;
        rd_check("iack_status", ADDR_STATUS, 32'h0002_0000);

        // CMP wrap-around
        do_reset();
        wr(ADDR_CMP, 32'hFFFF_FFFE);
        wr(ADDR_PERIOD, 32'd4);
        wr(ADDR_CTRL, 32'd3);
        ramp(32'hFFFF_FFFC, 4);
        check("wrap_fire0", fire_at(0), 32'hFFFF_FFFE);
        rd_check("wrap_cmp", ADDR_CMP, 32'd2);
        ramp(32'd0, 4);
        check("wrap_nfires", 32'(fires_q.size()), 32'd1);
        check("wrap_fire1", fire_at(0), 32'd2);

        // CMP write in the match cycle suppresses the fire
        do_reset();
        wr(ADDR_CMP, 32'd5);
        wr(ADDR_CTRL, 32'd1);
        ramp(32'd0, 5);
        TIME = 32'd5;
        wr(ADDR_CMP, 32'd9);
        rd_check("wrwin_status", ADDR_STATUS, 32'd0);
        ramp(32'd6, 5);
        check("wrwin_fire", fire_at(0), 32'd9);

        // Asynchronous reset while armed with IRQ high
        do_reset();
        wr(ADDR_CMP, 32'd3);
        wr(ADDR_PERIOD, 32'd4);
        wr(ADDR_CTRL, 32'd3);
        ramp(32'd0, 5);
        check("arst_pre_irq", 32'(IRQ), 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("arst_irq", 32'(IRQ), 32'd0);
        rd_check("arst_cmp",    ADDR_CMP,    32'd0);
        rd_check("arst_period", ADDR_PERIOD, 32'd0);
        rd_check("arst_ctrl",   ADDR_CTRL,   32'd0);
        rd_check("arst_status", ADDR_STATUS, 32'd0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        ramp(32'd0, 10);
        check("arst_idle_nfires", 32'(fires_q.size()), 32'd0);

        // Randomized run against the reference model
        do_reset();
        model_reset();
        t_rnd = '0;
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 15))
                0, 1:    t_rnd = t_rnd;
                2:       t_rnd = 32'($urandom_range(0, 15));
                default: t_rnd = (t_rnd + 32'd1) & 32'hF;
            endcase
            TIME = t_rnd;
            WE   = ($urandom_range(0, 3) == 0);
            ADDR = 2'($urandom_range(0, 3));
            case (ADDR)
                2'd0:    Di = 32'($urandom_range(0, 15));
                2'd1:    Di = 32'($urandom_range(0, 5));
                2'd2:    Di = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) | 32'd1);
                default: Di = 32'($urandom);
            endcase
            IACK = ($urandom_range(0, 15) == 0);
            #2;
            check("rnd_do", Do, model_do(ADDR));
            check("rnd_irq", 32'(IRQ), 32'(m_pend));
            model_step(WE, ADDR, Di, IACK, TIME);
            step();
        end
        WE = 1'b0;
        IACK = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
